// File: rtl/mod_counter_sched_pkg.sv
// mod_counter_sched shared types and constants.
// State encoding, grant ids and default widths.
package mod_counter_sched_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_REP_W = 4;

  localparam logic GRANT_REQ0 = 1'b0;
  localparam logic GRANT_REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod_counter_sched_arb.sv
// rr_arb2: two-way round-robin arbiter.
// Grants the sole valid, or on a tie the one not granted last.
module rr_arb2
  import mod_counter_sched_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic both;
  logic only0;
  logic only1;

  assign both  = (valid == 2'b11);
  assign only0 = (valid == 2'b01);
  assign only1 = (valid == 2'b10);

  // pick a winner; gnt stays zero with no valid
  always_comb begin
    gnt    = 2'b00;
    gnt_id = GRANT_REQ0;
    unique case (1'b1)
      both: begin
        gnt_id = ~last_grant;
        gnt    = gnt_id ? 2'b10 : 2'b01;
      end
      only0: begin
        gnt_id = GRANT_REQ0;
        gnt    = 2'b01;
      end
      only1: begin
        gnt_id = GRANT_REQ1;
        gnt    = 2'b10;
      end
      default: begin
        gnt    = 2'b00;
        gnt_id = GRANT_REQ0;
      end
    endcase
  end

endmodule

// File: rtl/mod_counter_sched.sv
// Shared modulus up-counter for two round-robin requesters.
// Optional pause input under MOD_COUNTER_SCHED_PAUSE_EN.
module mod_counter_sched
  import mod_counter_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MOD_COUNTER_SCHED_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_mod,
  input  logic [REP_W-1:0] req0_rep,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_mod,
  input  logic [REP_W-1:0] req1_rep,
  output logic             req1_ready,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             grant_id,
  output logic             wrap,
  output logic             done0,
  output logic             done1
);

  localparam logic [WIDTH:0]   ONE_X = 1;
  localparam logic [REP_W-1:0] ONE_R = 1;
  localparam logic [WIDTH-1:0] ONE_C = 1;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] count_q;
  logic [REP_W-1:0] wraps_q;
  logic [WIDTH-1:0] m_q;
  logic [REP_W-1:0] r_q;
  logic             gid_q;
  logic             last_q;

  logic [1:0]       arb_gnt;
  logic             arb_id;
  logic             fire;
  logic [WIDTH-1:0] sel_mod;
  logic [REP_W-1:0] sel_rep;

  logic [WIDTH:0]   m_eff;
  logic [WIDTH:0]   lim;
  logic [REP_W-1:0] r_last;
  logic             at_lim;
  logic             run_en;
  logic             last_wrap;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_q),
    .gnt        (arb_gnt),
    .gnt_id     (arb_id)
  );

  assign req0_ready = (state_q == IDLE) && arb_gnt[0];
  assign req1_ready = (state_q == IDLE) && arb_gnt[1];
  assign fire       = req0_ready | req1_ready;

  assign sel_mod = arb_id ? req1_mod : req0_mod;
  assign sel_rep = arb_id ? req1_rep : req0_rep;

  // M=0 stands for the full 2^WIDTH range
  always_comb begin
    m_eff = {1'b0, m_q};
    if (m_q == '0) begin
      m_eff = {1'b1, {WIDTH{1'b0}}};
    end
    lim = m_eff - ONE_X;
  end

  // R=0 behaves as a single pass
  always_comb begin
    r_last = r_q - ONE_R;
    if (r_q == '0) begin
      r_last = '0;
    end
  end

  assign at_lim = ({1'b0, count_q} >= lim);

`ifdef MOD_COUNTER_SCHED_PAUSE_EN
  assign run_en = (state_q == RUN) && !pause;
`else
  assign run_en = (state_q == RUN);
`endif

  assign wrap      = run_en && at_lim;
  assign last_wrap = wrap && (wraps_q == r_last);

  assign count    = count_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = gid_q;
  assign done0    = (state_q == DONE) && (gid_q == GRANT_REQ0);
  assign done1    = (state_q == DONE) && (gid_q == GRANT_REQ1);

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_wrap) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // job latch, counter and wrap counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      wraps_q <= '0;
      m_q     <= '0;
      r_q     <= '0;
      gid_q   <= GRANT_REQ0;
      last_q  <= GRANT_REQ1;
    end else begin
      unique case (state_q)
        IDLE: begin
          count_q <= '0;
          if (fire) begin
            m_q     <= sel_mod;
            r_q     <= sel_rep;
            gid_q   <= arb_id;
            last_q  <= arb_id;
            wraps_q <= '0;
          end
        end
        RUN: begin
          if (run_en) begin
            if (at_lim) begin
              count_q <= '0;
              wraps_q <= wraps_q + ONE_R;
            end else begin
              count_q <= count_q + ONE_C;
            end
          end
        end
        DONE: begin
          count_q <= '0;
        end
        default: begin
          count_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_counter_sched.sv
// Self-checking bench for mod_counter_sched.
// Directed plan steps plus randomized jobs vs. a job-level model.
module tb_mod_counter_sched;

  localparam int WIDTH = 8;
  localparam int REP_W = 4;

  logic             clk;
  logic             rst;
  logic             pause;
  logic             req0_valid;
  logic [WIDTH-1:0] req0_mod;
  logic [REP_W-1:0] req0_rep;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_mod;
  logic [REP_W-1:0] req1_rep;
  logic             req1_ready;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             grant_id;
  logic             wrap;
  logic             done0;
  logic             done1;

  int vectors;
  int miscompares;
  int model_last;

  mod_counter_sched #(
    .WIDTH (WIDTH),
    .REP_W (REP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef MOD_COUNTER_SCHED_PAUSE_EN
    .pause      (pause),
`endif
    .req0_valid (req0_valid),
    .req0_mod   (req0_mod),
    .req0_rep   (req0_rep),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_mod   (req1_mod),
    .req1_rep   (req1_rep),
    .req1_ready (req1_ready),
    .count      (count),
    .busy       (busy),
    .grant_id   (grant_id),
    .wrap       (wrap),
    .done0      (done0),
    .done1      (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int meff_of(input int m);
    return (m == 0) ? (1 << WIDTH) : m;
  endfunction

  function automatic int reff_of(input int r);
    return (r == 0) ? 1 : r;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_done0"}, 32'(done0), 0);
    chk({tag, "_done1"}, 32'(done1), 0);
    chk({tag, "_wrap"}, 32'(wrap), 0);
  endtask

  // Offer a job; the model picks the winner and returns its job.
  task automatic start(input bit v0, input bit v1,
                       input int m0, input int r0,
                       input int m1, input int r1,
                       output int w, output int meff, output int reff);
    @(negedge clk);
    req0_valid = v0;
    req1_valid = v1;
    req0_mod   = WIDTH'(m0);
    req0_rep   = REP_W'(r0);
    req1_mod   = WIDTH'(m1);
    req1_rep   = REP_W'(r1);
    if (v0 && v1) w = 1 - model_last;
    else w = v1 ? 1 : 0;
    meff = (w == 1) ? meff_of(m1) : meff_of(m0);
    reff = (w == 1) ? reff_of(r1) : reff_of(r0);
    #1;
    chk("ready0", 32'(req0_ready), 32'(w == 0));
    chk("ready1", 32'(req1_ready), 32'(w == 1));
    model_last = w;
    @(posedge clk);
  endtask

  // DONE cycle then one IDLE cycle
  task automatic finish(input int w);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("done0", 32'(done0), 32'(w == 0));
    chk("done1", 32'(done1), 32'(w == 1));
    chk("done_count", 32'(count), 0);
    chk("done_busy", 32'(busy), 1);
    chk("done_gid", 32'(grant_id), 32'(w));
    @(negedge clk);
    #1;
    chk_idle("post");
  endtask

  // RUN cycle k shows k mod M; req port activity is ignored
  task automatic run_job(input int w, input int meff, input int reff);
    int c;
    for (int k = 0; k < meff * reff; k++) begin
      @(negedge clk);
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_mod   = WIDTH'($urandom);
      req1_mod   = WIDTH'($urandom);
      req0_rep   = REP_W'($urandom);
      req1_rep   = REP_W'($urandom);
      #1;
      c = k % meff;
      chk("count", 32'(count), 32'(c));
      chk("wrap", 32'(wrap), 32'(c == meff - 1));
      chk("busy", 32'(busy), 1);
      chk("gid", 32'(grant_id), 32'(w));
      chk("run_rdy", 32'({req1_ready, req0_ready}), 0);
      chk("run_done", 32'({done1, done0}), 0);
    end
    finish(w);
  endtask

  task automatic job(input bit v0, input bit v1,
                     input int m0, input int r0,
                     input int m1, input int r1);
    int w;
    int me;
    int re;
    start(v0, v1, m0, r0, m1, r1, w, me, re);
    run_job(w, me, re);
  endtask

  initial begin
    int w;
    int me;
    int re;
    vectors     = 0;
    miscompares = 0;
    model_last  = 1;
    rst         = 1'b0;
    pause       = 1'b0;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    req0_mod    = '0;
    req0_rep    = '0;
    req1_mod    = '0;
    req1_rep    = '0;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_idle("reset");
    chk("reset_gid", 32'(grant_id), 0);
    chk("reset_rdy", 32'({req1_ready, req0_ready}), 0);

    // req0 M=3 R=2
    job(1'b1, 1'b0, 3, 2, 0, 0);

    // ties alternate, starting from req0 after reset
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_last = 1;
    job(1'b1, 1'b1, 2, 1, 2, 1);
    job(1'b1, 1'b1, 2, 1, 3, 1);
    job(1'b1, 1'b1, 4, 1, 2, 1);

    // M=1 R=3 and full-range M=0 R=0
    job(1'b0, 1'b1, 0, 0, 1, 3);
    job(1'b1, 1'b0, 0, 0, 0, 0);

    // no valid keeps IDLE
    repeat (3) begin
      @(negedge clk);
      #1;
      chk_idle("novalid");
    end

    // reset mid-job at count 5
    start(1'b1, 1'b0, 10, 2, 0, 0, w, me, re);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      chk("pre_abort", 32'(count), 32'(k));
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk_idle("abort");
    chk("abort_gid", 32'(grant_id), 0);
    rst = 1'b1;
    model_last = 1;
    @(negedge clk);
    #1;
    chk_idle("abort_after");

`ifdef MOD_COUNTER_SCHED_PAUSE_EN
    begin
      int pc[7];
      int pp[7];
      pc = '{0, 1, 2, 2, 2, 2, 3};
      pp = '{0, 0, 1, 1, 1, 0, 0};
      start(1'b1, 1'b0, 4, 1, 0, 0, w, me, re);
      for (int k = 0; k < 7; k++) begin
        @(negedge clk);
        req0_valid = 1'b0;
        pause = 1'(pp[k]);
        #1;
        chk("p_count", 32'(count), 32'(pc[k]));
        chk("p_wrap", 32'(wrap), 32'(k == 6));
        chk("p_busy", 32'(busy), 1);
      end
      pause = 1'b0;
      finish(w);
    end
`endif

    // randomized jobs
    for (int n = 0; n < 24; n++) begin
      int v;
      int ma;
      int mb;
      v  = $urandom_range(1, 3);
      ma = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      mb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      job(v[0], v[1], ma, $urandom_range(0, 3), mb, $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        #1;
        chk_idle("gap");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
